// File: rtl/matrix_fifo_loader.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_fifo_loader
//  Description : Avalon-MM read master that fetches an N x N A matrix (words
//                0..N-1) and an N-element B vector (word N) and serialises
//                the bytes into the per-row A FIFOs and the B FIFO of the
//                downstream matrix-vector multiply stage.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLOCK_50           clock, rising edge
//    rst                synchronous active-high reset
//    start, base_addr   load request and byte address of word 0
//    avm_*              Avalon-MM read master (one read outstanding at most)
//    a_full, b_full     downstream FIFO full flags
//    a_wren, a_data     one-hot A FIFO write enables, flattened write data
//    b_wren, b_data     B FIFO write enable and data
//    busy, done         not-idle status and end-of-load pulse
//    load_cycles        busy-cycle counter (only with the macro below)
//  Optional feature
//    `define MATRIX_LOADER_CYCLE_COUNT_EN adds the load_cycles output.
// ============================================================================
module matrix_fifo_loader #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    CLOCK_50,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  output logic [ADDR_WIDTH-1:0]   avm_address,
  output logic                    avm_read,
  input  logic                    avm_waitrequest,
  input  logic [N*DATA_WIDTH-1:0] avm_readdata,
  input  logic                    avm_readdatavalid,
  input  logic [N-1:0]            a_full,
  input  logic                    b_full,
  output logic [N-1:0]            a_wren,
  output logic [N*DATA_WIDTH-1:0] a_data,
  output logic                    b_wren,
  output logic [DATA_WIDTH-1:0]   b_data,
  output logic                    busy,
  output logic                    done
`ifdef MATRIX_LOADER_CYCLE_COUNT_EN
  ,
  output logic [15:0]             load_cycles
`endif
);

  localparam int WIDX_W = $clog2(N + 1);
  localparam int BIDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_RESP   = 3'd2,
    S_UNPACK = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [WIDX_W-1:0]       word_idx_q, word_idx_d;
  logic [BIDX_W-1:0]       byte_idx_q, byte_idx_d;
  logic [N*DATA_WIDTH-1:0] latch_q, latch_d;
  logic [ADDR_WIDTH-1:0]   avm_address_q, avm_address_d;
  logic                    avm_read_q, avm_read_d;
  logic [N-1:0]            a_wren_q, a_wren_d;
  logic [N*DATA_WIDTH-1:0] a_data_q, a_data_d;
  logic                    b_wren_q, b_wren_d;
  logic [DATA_WIDTH-1:0]   b_data_q, b_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [DATA_WIDTH-1:0]   cur_byte;
  logic                    target_full;
  logic                    target_is_b;
  logic                    last_byte;

  // Byte currently being unpacked from the latched word.
  always_comb begin
    cur_byte = '0;
    for (int b = 0; b < N; b++) begin
      if (byte_idx_q == BIDX_W'(b)) begin
        cur_byte = latch_q[b*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Full flag of the FIFO that the current word feeds; word N is the B vector.
  always_comb begin
    target_is_b = (word_idx_q == WIDX_W'(N));
    target_full = b_full;
    for (int r = 0; r < N; r++) begin
      if (word_idx_q == WIDX_W'(r)) begin
        target_full = a_full[r];
      end
    end
  end

  assign last_byte = (byte_idx_q == BIDX_W'(N - 1));

  always_comb begin
    state_d       = state_q;
    word_idx_d    = word_idx_q;
    byte_idx_d    = byte_idx_q;
    latch_d       = latch_q;
    avm_address_d = avm_address_q;
    avm_read_d    = avm_read_q;
    // Write strobes and data are single-cycle; they fall back to zero.
    a_wren_d      = '0;
    a_data_d      = '0;
    b_wren_d      = 1'b0;
    b_data_d      = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          avm_address_d = base_addr;
          avm_read_d    = 1'b1;
          word_idx_d    = '0;
          state_d       = S_REQ;
        end
      end

      S_REQ: begin
        // Address and read stay registered until the slave stops stalling.
        if (!avm_waitrequest) begin
          avm_read_d = 1'b0;
          state_d    = S_RESP;
        end
      end

      S_RESP: begin
        if (avm_readdatavalid) begin
          latch_d    = avm_readdata;
          byte_idx_d = '0;
          state_d    = S_UNPACK;
        end
      end

      S_UNPACK: begin
        if (!target_full) begin
          if (target_is_b) begin
            b_wren_d = 1'b1;
            b_data_d = cur_byte;
          end else begin
            for (int r = 0; r < N; r++) begin
              if (word_idx_q == WIDX_W'(r)) begin
                a_wren_d[r]                          = 1'b1;
                a_data_d[r*DATA_WIDTH +: DATA_WIDTH] = cur_byte;
              end
            end
          end

          if (last_byte) begin
            byte_idx_d = '0;
            if (target_is_b) begin
              state_d = S_DONE;
            end else begin
              word_idx_d    = word_idx_q + WIDX_W'(1);
              avm_address_d = avm_address_q + ADDR_WIDTH'(N);
              avm_read_d    = 1'b1;
              state_d       = S_REQ;
            end
          end else begin
            byte_idx_d = byte_idx_q + BIDX_W'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d    = S_IDLE;
        avm_read_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q       <= S_IDLE;
      word_idx_q    <= '0;
      byte_idx_q    <= '0;
      latch_q       <= '0;
      avm_address_q <= '0;
      avm_read_q    <= 1'b0;
      a_wren_q      <= '0;
      a_data_q      <= '0;
      b_wren_q      <= 1'b0;
      b_data_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_idx_q    <= word_idx_d;
      byte_idx_q    <= byte_idx_d;
      latch_q       <= latch_d;
      avm_address_q <= avm_address_d;
      avm_read_q    <= avm_read_d;
      a_wren_q      <= a_wren_d;
      a_data_q      <= a_data_d;
      b_wren_q      <= b_wren_d;
      b_data_q      <= b_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign avm_address = avm_address_q;
  assign avm_read    = avm_read_q;
  assign a_wren      = a_wren_q;
  assign a_data      = a_data_q;
  assign b_wren      = b_wren_q;
  assign b_data      = b_data_q;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef MATRIX_LOADER_CYCLE_COUNT_EN
  logic [15:0] load_cycles_q, load_cycles_d;

  // Counts every cycle spent outside IDLE; cleared by an accepted start and
  // left untouched afterwards so the last load's figure stays readable.
  always_comb begin
    load_cycles_d = load_cycles_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        load_cycles_d = '0;
      end
    end else if (load_cycles_q != 16'hFFFF) begin
      load_cycles_d = load_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      load_cycles_q <= '0;
    end else begin
      load_cycles_q <= load_cycles_d;
    end
  end

  assign load_cycles = load_cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matrix_fifo_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_fifo_loader
//  Description : Self-checking bench for matrix_fifo_loader. A memory model
//                answers reads with latency 1; expected FIFO writes and read
//                addresses are queued when a load is started and compared as
//                the design produces them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_matrix_fifo_loader;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int AW = 32;

  logic              CLOCK_50 = 1'b0;
  logic              rst;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [AW-1:0]     avm_address;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [N*DW-1:0]   avm_readdata;
  logic              avm_readdatavalid;
  logic [N-1:0]      a_full;
  logic              b_full;
  logic [N-1:0]      a_wren;
  logic [N*DW-1:0]   a_data;
  logic              b_wren;
  logic [DW-1:0]     b_data;
  logic              busy;
  logic              done;
`ifdef MATRIX_LOADER_CYCLE_COUNT_EN
  logic [15:0]       load_cycles;
`endif

  always #5 CLOCK_50 = ~CLOCK_50;

  matrix_fifo_loader #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLOCK_50          (CLOCK_50),
    .rst               (rst),
    .start             (start),
    .base_addr         (base_addr),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .a_full            (a_full),
    .b_full            (b_full),
    .a_wren            (a_wren),
    .a_data            (a_data),
    .b_wren            (b_wren),
    .b_data            (b_data),
    .busy              (busy),
    .done              (done)
`ifdef MATRIX_LOADER_CYCLE_COUNT_EN
    ,
    .load_cycles       (load_cycles)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: {target, byte} per FIFO write (target N = B FIFO), and read addresses.
  logic [15:0]   wr_q[$];
  logic [AW-1:0] addr_q[$];

  // Shared memory-model / monitor state.
  bit            pend       = 0;
  logic [AW-1:0] pend_addr  = '0;
  logic [AW-1:0] cur_base   = '0;
  logic [AW-1:0] stall_addr = '0;
  int            stall_left = 0;
  bit            stall_on   = 0;
  bit            bp_armed   = 0;
  int            bp_left    = 0;
  int            bp_t3      = 0;
  int            neg_idx    = 0;
  int            done_cnt   = 0;
  bit            stray_req  = 0;

  function automatic logic [7:0] mem_byte(input int w, input int b);
    if (w == N) return 8'hF0 + 8'(b);
    return 8'(w * 8 + b);
  endfunction

  function automatic logic [N*DW-1:0] mem_word(input int w);
    logic [N*DW-1:0] v;
    v = '0;
    for (int b = 0; b < N; b++) v[b*DW +: DW] = mem_byte(w, b);
    return v;
  endfunction

  task automatic push_load(input logic [AW-1:0] base);
    for (int w = 0; w <= N; w++) begin
      addr_q.push_back(base + AW'(w * N));
      for (int b = 0; b < N; b++) wr_q.push_back({8'(w), mem_byte(w, b)});
    end
  endtask

  // Memory model, FIFO-side monitor and backpressure control, all on the falling edge.
  initial begin : mem_and_monitor
    logic [7:0]  tgt;
    logic [7:0]  dat;
    logic [15:0] exp_wr;
    forever begin
      @(negedge CLOCK_50);
      neg_idx++;

      if (bp_left > 0) begin
        bp_left--;
        if (bp_left == 0) a_full = '0;
      end

      if (a_wren != '0 || b_wren) begin
        check_eq("wr_onehot", 64'($countones(a_wren) + int'(b_wren)), 64'd1);
        tgt = 8'(N);
        dat = b_data;
        for (int r = 0; r < N; r++) begin
          if (a_wren[r]) begin
            tgt = 8'(r);
            dat = a_data[r*DW +: DW];
          end
        end
        check_eq("wr_expected", 64'(wr_q.size() > 0), 64'd1);
        if (wr_q.size() > 0) begin
          exp_wr = wr_q.pop_front();
          check_eq("wr_data", {tgt, dat}, exp_wr);
        end
        if (bp_armed && tgt == 8'd2 && dat == 8'd19) begin
          a_full[2] = 1'b1;
          bp_left   = 4;
          bp_armed  = 0;
          bp_t3     = neg_idx;
        end else if (tgt == 8'd2 && dat == 8'd20 && bp_t3 != 0) begin
          check_eq("bp_gap", 64'(neg_idx - bp_t3), 64'd5);
          bp_t3 = 0;
        end
      end

      if (done) done_cnt++;

      avm_readdatavalid = 1'b0;
      if (stray_req) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = 64'hDEAD_BEEF_CAFE_F00D;
        stray_req         = 0;
      end else if (pend) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = mem_word(int'((pend_addr - cur_base) >> 3));
        pend              = 0;
      end

      if (!stall_on && stall_left > 0 && avm_read && avm_address == stall_addr) stall_on = 1;
      if (stall_on) begin
        check_eq("stall_read", 64'(avm_read), 64'd1);
        check_eq("stall_addr", 64'(avm_address), 64'(stall_addr));
      end
      if (stall_on && stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else begin
        avm_waitrequest = 1'b0;
        stall_on        = 0;
      end

      if (avm_read && !avm_waitrequest) begin
        pend      = 1;
        pend_addr = avm_address;
        check_eq("rd_expected", 64'(addr_q.size() > 0), 64'd1);
        if (addr_q.size() > 0) check_eq("rd_addr", 64'(avm_address), 64'(addr_q.pop_front()));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_read"},  64'(avm_read), 64'd0);
    check_eq({tag, "_addr"},  64'(avm_address), 64'd0);
    check_eq({tag, "_awren"}, 64'(a_wren), 64'd0);
    check_eq({tag, "_adata"}, a_data, 64'd0);
    check_eq({tag, "_bwren"}, 64'(b_wren), 64'd0);
    check_eq({tag, "_bdata"}, 64'(b_data), 64'd0);
    check_eq({tag, "_busy"},  64'(busy), 64'd0);
    check_eq({tag, "_done"},  64'(done), 64'd0);
  endtask

  // One full load; optionally pulses a second start while word 4 is requested.
  task automatic run_load(input string tag, input logic [AW-1:0] base, input int exp_lat,
                          input bit poke);
    int n;
    int d0;
    bit poked;
    cur_base = base;
    push_load(base);
    d0 = done_cnt;
    poked = 0;
    @(negedge CLOCK_50);
    base_addr = base;
    start     = 1'b1;
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
      start = 1'b0;
      if (poke && !poked && avm_read && avm_address == base + 32'h20) begin
        start     = 1'b1;
        base_addr = 32'h800;
        poked     = 1;
      end
    end while (!done && n < 400);
    check_eq({tag, "_latency"}, 64'(n), 64'(exp_lat));
    repeat (4) @(negedge CLOCK_50);
    check_eq({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check_eq({tag, "_wr_left"}, 64'(wr_q.size()), 64'd0);
    check_eq({tag, "_rd_left"}, 64'(addr_q.size()), 64'd0);
    check_eq({tag, "_busy_after"}, 64'(busy), 64'd0);
`ifdef MATRIX_LOADER_CYCLE_COUNT_EN
    check_eq({tag, "_load_cycles"}, 64'(load_cycles), 64'(exp_lat));
`endif
    wr_q.delete();
    addr_q.delete();
  endtask

  initial begin : main
    int n;
    rst               = 1'b1;
    start             = 1'b0;
    base_addr         = '0;
    avm_waitrequest   = 1'b0;
    avm_readdata      = '0;
    avm_readdatavalid = 1'b0;
    a_full            = '0;
    b_full            = 1'b0;

    repeat (3) @(negedge CLOCK_50);
    check_all_zero("reset");
`ifdef MATRIX_LOADER_CYCLE_COUNT_EN
    check_eq("reset_load_cycles", 64'(load_cycles), 64'd0);
`endif
    rst = 1'b0;
    repeat (2) @(negedge CLOCK_50);

    run_load("basic", 32'h100, 91, 0);

    stall_addr = 32'h118;
    stall_left = 5;
    run_load("stall", 32'h100, 96, 0);

    bp_armed = 1;
    run_load("bp", 32'h100, 95, 0);

    run_load("busy_start", 32'h400, 91, 1);

    // Reset while unpacking word 5, then a stray read response.
    cur_base = 32'h200;
    push_load(32'h200);
    @(negedge CLOCK_50);
    base_addr = 32'h200;
    start     = 1'b1;
    n = 0;
    do begin
      @(negedge CLOCK_50);
      start = 1'b0;
      n++;
    end while (!a_wren[5] && n < 400);
    check_eq("rst_reached_row5", 64'(a_wren[5]), 64'd1);
    rst = 1'b1;
    @(negedge CLOCK_50);
    rst = 1'b0;
    check_all_zero("midrst");
    wr_q.delete();
    addr_q.delete();
    stray_req = 1;
    repeat (4) begin
      @(negedge CLOCK_50);
      check_eq("stray_awren", 64'(a_wren), 64'd0);
      check_eq("stray_bwren", 64'(b_wren), 64'd0);
    end
    check_eq("stray_busy", 64'(busy), 64'd0);

    run_load("after_rst", 32'h300, 91, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
